// File: rtl/shift_pkg.sv
// shift_pkg: shared shift-op encoding, FSM state type and parameter defaults
// for the serial shifter and the datapath shifter/decoder.
package shift_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AMT_W_DEF = 4;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-bit shift of a WIDTH-bit word by op,
// returning the shifted word and the bit shifted out.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_r,
    input  shift_op_t        i_op,
    output logic [WIDTH-1:0] o_r_next,
    output logic             o_carry
);

    always_comb begin
        o_r_next = i_r;
        o_carry  = 1'b0;
        case (i_op)
            SH_LSL: begin
                o_r_next = {i_r[WIDTH-2:0], 1'b0};
                o_carry  = i_r[WIDTH-1];
            end
            SH_LSR: begin
                o_r_next = {1'b0, i_r[WIDTH-1:1]};
                o_carry  = i_r[0];
            end
            SH_ASR: begin
                o_r_next = {i_r[WIDTH-1], i_r[WIDTH-1:1]};
                o_carry  = i_r[0];
            end
            default: begin
                o_r_next = i_r;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle shifter, one bit per clock, with start/busy/done
// handshake; carry_out holds the last bit shifted out.
module serial_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [1:0]       shift_op,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shift_out,
    output logic             carry_out
);

    state_t           r_state;
    state_t           w_next_state;
    logic [AMT_W-1:0] r_cnt;
    shift_op_t        r_op;
    logic             w_accept;
    logic [WIDTH-1:0] w_step;
    logic             w_carry;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_r      (shift_out),
        .i_op     (r_op),
        .o_r_next (w_step),
        .o_carry  (w_carry)
    );

    // A start arriving during SHIFT is dropped, not queued.
    assign w_accept = start && (r_state != ST_SHIFT);

    always_comb begin
        w_next_state = ST_IDLE;
        if (w_accept)
            w_next_state = (shift_amt == '0) ? ST_DONE : ST_SHIFT;
        else if (r_state == ST_SHIFT)
            w_next_state = (r_cnt == AMT_W'(1)) ? ST_DONE : ST_SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= SH_NONE;
            shift_out <= '0;
            carry_out <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                shift_out <= shift_in;
                carry_out <= 1'b0;
                r_op      <= shift_op_t'(shift_op);
                r_cnt     <= shift_amt;
            end else if (r_state == ST_SHIFT) begin
                shift_out <= w_step;
                carry_out <= w_carry;
                r_cnt     <= r_cnt - AMT_W'(1);
            end
        end
    end

    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: table-driven checks of serial_shifter results and latency,
// plus directed sequences for reset, ignored start, back-to-back and hold.
module tb_serial_shifter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] shift_in = '0;
    logic [1:0]  shift_op = '0;
    logic [3:0]  shift_amt = '0;
    logic        busy;
    logic        done;
    logic [15:0] shift_out;
    logic        carry_out;

    int checks = 0;
    int errors = 0;

    serial_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .shift_in  (shift_in),
        .shift_op  (shift_op),
        .shift_amt (shift_amt),
        .busy      (busy),
        .done      (done),
        .shift_out (shift_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] din;
        logic [15:0] dout;
        logic        c;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " shift_out"}, 32'(shift_out), 32'h0000);
        check({tag, " carry_out"}, 32'(carry_out), 32'd0);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat = 0;
        int nbusy = 0;
        @(negedge clk);
        start = 1'b1;
        shift_in = v.din;
        shift_op = v.op;
        shift_amt = v.amt;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(v.amt) + 32'd1);
        check({tag, " busy cycles"}, 32'(nbusy), 32'(v.amt));
        check({tag, " shift_out"}, 32'(shift_out), 32'(v.dout));
        check({tag, " carry_out"}, 32'(carry_out), 32'(v.c));
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        logic [15:0] hold_out;
        logic        hold_c;
        vecs[0] = '{2'b01, 4'd1,  16'h8001, 16'h0002, 1'b1};
        vecs[1] = '{2'b01, 4'd4,  16'h1234, 16'h2340, 1'b1};
        vecs[2] = '{2'b10, 4'd15, 16'h8000, 16'h0001, 1'b0};
        vecs[3] = '{2'b11, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
        vecs[4] = '{2'b11, 4'd1,  16'h0003, 16'h0001, 1'b1};
        vecs[5] = '{2'b11, 4'd0,  16'hBEEF, 16'hBEEF, 1'b0};
        vecs[6] = '{2'b00, 4'd7,  16'hBEEF, 16'hBEEF, 1'b0};
        vecs[7] = '{2'b10, 4'd5,  16'h00F0, 16'h0007, 1'b1};
        vecs[8] = '{2'b01, 4'd2,  16'hC000, 16'h0000, 1'b1};

        #2;
        check_reset("initial reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++)
            run_op(vecs[k], $sformatf("vec%0d", k));

        // Hold: operands wiggle with start low; result must not move.
        hold_out = shift_out;
        hold_c = carry_out;
        for (int k = 0; k < 5; k++) begin
            shift_in = 16'(16'h1111 * (k + 1));
            shift_op = 2'(k);
            shift_amt = 4'(k + 3);
            @(negedge clk);
            check("hold shift_out", 32'(shift_out), 32'(hold_out));
            check("hold carry_out", 32'(carry_out), 32'(hold_c));
            check("hold busy", 32'(busy), 32'd0);
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start pulsed during SHIFT is ignored.
        start = 1'b1; shift_in = 16'h0001; shift_op = 2'b01; shift_amt = 4'd3;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin
                shift_in = 16'hFFFF; shift_op = 2'b10; shift_amt = 4'd1;
            end
            if (done) begin
                ndone = i;
                break;
            end
        end
        start = 1'b0;
        check("ignored start latency", 32'(ndone), 32'd4);
        check("ignored start shift_out", 32'(shift_out), 32'h0008);
        check("ignored start carry_out", 32'(carry_out), 32'd0);
        @(negedge clk);

        // Back-to-back: start held high through DONE.
        start = 1'b1; shift_in = 16'h0001; shift_op = 2'b01; shift_amt = 4'd2;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("b2b first latency", 32'(i), 32'd3);
                    check("b2b first shift_out", 32'(shift_out), 32'h0004);
                    shift_in = 16'h0085; shift_op = 2'b10; shift_amt = 4'd3;
                end else begin
                    check("b2b second latency", 32'(i), 32'd7);
                    check("b2b second shift_out", 32'(shift_out), 32'h0010);
                    check("b2b second carry_out", 32'(carry_out), 32'd1);
                end
            end
            if (i == 4) check("b2b reload busy", 32'(busy), 32'd1);
        end
        check("b2b done pulses", 32'(ndone), 32'd2);

        // Reset during SHIFT: no done pulse afterwards.
        @(negedge clk);
        start = 1'b1; shift_in = 16'h5555; shift_op = 2'b01; shift_amt = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-shift busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("mid-shift reset");
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no done after reset", 32'(ndone), 32'd0);
        check("idle after reset", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
